// File: rtl/pred_pipe_rx_pkg.sv
// pred_pipe_rx_pkg
//   Shared defaults and helpers for the pred_pipe_rx credit-flow receiver.
//   DEF_WIDTH / DEF_DEPTH : default beat width and FIFO depth (= initial credits)
//   occ_w()               : bit width needed to hold an occupancy of 0..DEPTH
package pred_pipe_rx_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pred_pipe_rx_fifo.sv
// pred_pipe_rx_fifo
//   Storage for pred_pipe_rx: register array, wrapping read/write pointers,
//   registered occupancy count and full/empty flags derived from it.
//   clk, rst  : clock, synchronous active-high reset (control state only)
//   push      : write wr_data at the write pointer
//   pop       : advance the read pointer (caller guarantees not empty)
//   rd_data   : entry at the read pointer
//   occupancy : number of stored entries, 0..DEPTH
//   full      : occupancy == DEPTH
//   empty     : occupancy == 0
module pred_pipe_rx_fifo
    import pred_pipe_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [occ_w(DEPTH)-1:0]    occupancy,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Payload storage carries no reset; validity is tracked by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (occupancy == OCC_W'(DEPTH));
    assign empty   = (occupancy == '0);

endmodule

// File: rtl/pred_pipe_rx.sv
// pred_pipe_rx
//   Receiving end of a predicated credit-flow link. Accepted beats are queued
//   in a DEPTH-entry FIFO, offered on a ready/valid port, and every drained beat
//   returns one credit to the producer as a one-cycle credit_release pulse.
//   Build option: define PRED_PIPE_RX_BYPASS_EN to let a beat arriving at an
//   empty FIFO appear on out_* in the same cycle (and skip storage if taken).
//   clk, rst       : clock, synchronous active-high reset
//   in_pred        : upstream beat qualifier
//   in_data        : upstream beat payload
//   credit_release : one-cycle pulse, one credit back to the producer
//   out_valid      : head entry available
//   out_ready      : consumer accepts head
//   out_data       : head entry payload
//   occupancy      : current entry count
//   overflow       : sticky flag, producer sent while no credit was available
module pred_pipe_rx
    import pred_pipe_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_pred,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       credit_release,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [occ_w(DEPTH)-1:0]    occupancy,
    output logic                       overflow
);

    logic             pop_p0;
    logic             fifo_push;
    logic             fifo_pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] fifo_data;

    pred_pipe_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wr_data   (in_data),
        .rd_data   (fifo_data),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

`ifdef PRED_PIPE_RX_BYPASS_EN
    logic byp_p0;

    // An arriving beat at an empty FIFO is offered directly; if the consumer
    // takes it, it never touches storage, otherwise it is stored as usual.
    assign byp_p0    = empty && in_pred;
    assign out_valid = !empty || in_pred;
    assign out_data  = empty ? in_data : fifo_data;
    assign pop_p0    = out_valid && out_ready;
    assign fifo_pop  = pop_p0 && !empty;
    assign fifo_push = in_pred && !(byp_p0 && out_ready) && (!full || pop_p0);
`else
    assign out_valid = !empty;
    assign out_data  = fifo_data;
    assign pop_p0    = out_valid && out_ready;
    assign fifo_pop  = pop_p0;
    // A same-cycle pop frees the slot the push needs, so full does not block it.
    assign fifo_push = in_pred && (!full || pop_p0);
`endif

    // Stage p0 -> p1: credit return and protocol-violation tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_release <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            credit_release <= pop_p0;
            if (in_pred && full && !pop_p0) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pred_pipe_rx.sv
// tb_pred_pipe_rx
//   Directed-vector bench for pred_pipe_rx (WIDTH=8, DEPTH=4). Inputs change
//   1 time unit after each rising edge; outputs are sampled at that same point.
`timescale 1ns/1ps
module tb_pred_pipe_rx;

    logic       clk;
    logic       rst;
    logic       in_pred;
    logic [7:0] in_data;
    logic       credit_release;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] occupancy;
    logic       overflow;

    int checks;
    int errors;

    pred_pipe_rx #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_pred        (in_pred),
        .in_data        (in_data),
        .credit_release (credit_release),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .occupancy      (occupancy),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fill_vec  [4];
    logic [7:0] drain_vec [4];

    initial begin
        checks    = 0;
        errors    = 0;
        fill_vec  = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain_vec = '{8'h22, 8'h33, 8'h44, 8'h66};

        rst       = 1'b1;
        in_pred   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_valid",  {31'd0, out_valid},      32'd0);
        chk("rst_credit", {31'd0, credit_release}, 32'd0);
        chk("rst_occ",    {29'd0, occupancy},      32'd0);
        chk("rst_ovf",    {31'd0, overflow},       32'd0);
        rst = 1'b0;

        // Fill with consumer stalled
        for (int i = 0; i < 4; i++) begin
            in_pred = 1'b1;
            in_data = fill_vec[i];
            tick();
            chk("fill_occ",    {29'd0, occupancy},      32'(i + 1));
            chk("fill_credit", {31'd0, credit_release}, 32'd0);
            chk("fill_valid",  {31'd0, out_valid},      32'd1);
            chk("fill_head",   {24'd0, out_data},       32'h11);
        end
        in_pred = 1'b0;
        tick();
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data",  {24'd0, out_data},  32'h11);
        chk("hold_ovf",   {31'd0, overflow},  32'd0);

        // Full with simultaneous pop and push
        in_pred   = 1'b1;
        in_data   = 8'h66;
        out_ready = 1'b1;
        tick();
        chk("fsim_occ",    {29'd0, occupancy},      32'd4);
        chk("fsim_ovf",    {31'd0, overflow},       32'd0);
        chk("fsim_head",   {24'd0, out_data},       32'h22);
        chk("fsim_credit", {31'd0, credit_release}, 32'd1);

        // Overflow: full, stalled, beat presented
        in_data   = 8'h55;
        out_ready = 1'b0;
        tick();
        chk("ovf_flag",   {31'd0, overflow},       32'd1);
        chk("ovf_occ",    {29'd0, occupancy},      32'd4);
        chk("ovf_credit", {31'd0, credit_release}, 32'd0);
        chk("ovf_head",   {24'd0, out_data},       32'h22);
        in_pred = 1'b0;

        // Drain: 0x55 must not appear
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_data",  {24'd0, out_data},  32'(drain_vec[i]));
            tick();
            chk("drain_credit", {31'd0, credit_release}, 32'd1);
            chk("drain_occ",    {29'd0, occupancy},      32'(3 - i));
        end
        out_ready = 1'b0;
        tick();
        chk("drain_end_valid",  {31'd0, out_valid},      32'd0);
        chk("drain_end_credit", {31'd0, credit_release}, 32'd0);
        chk("drain_end_ovf",    {31'd0, overflow},       32'd1);

        // Reset mid-operation: occupancy 3 with a pop on the previous edge
        for (int i = 0; i < 4; i++) begin
            in_pred = 1'b1;
            in_data = 8'hA0 + 8'(i);
            tick();
        end
        in_pred   = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_occ", {29'd0, occupancy}, 32'd3);
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("mid_rst_valid",  {31'd0, out_valid},      32'd0);
        chk("mid_rst_occ",    {29'd0, occupancy},      32'd0);
        chk("mid_rst_credit", {31'd0, credit_release}, 32'd0);
        chk("mid_rst_ovf",    {31'd0, overflow},       32'd0);
        rst = 1'b0;
        tick();

        // Wrap-around streaming, consumer always ready
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_pred = 1'b1;
            in_data = 8'(k);
`ifdef PRED_PIPE_RX_BYPASS_EN
            #1;
            chk("wrap_byp_valid", {31'd0, out_valid}, 32'd1);
            chk("wrap_byp_data",  {24'd0, out_data},  32'(k));
            tick();
            chk("wrap_byp_occ",    {29'd0, occupancy},      32'd0);
            chk("wrap_byp_credit", {31'd0, credit_release}, 32'd1);
`else
            tick();
            chk("wrap_valid",  {31'd0, out_valid},      32'd1);
            chk("wrap_data",   {24'd0, out_data},       32'(k));
            chk("wrap_occ",    {29'd0, occupancy},      32'd1);
            chk("wrap_credit", {31'd0, credit_release}, (k > 0) ? 32'd1 : 32'd0);
`endif
        end
        in_pred = 1'b0;
        tick();
        chk("wrap_end_valid",  {31'd0, out_valid},      32'd0);
        chk("wrap_end_occ",    {29'd0, occupancy},      32'd0);
`ifdef PRED_PIPE_RX_BYPASS_EN
        chk("wrap_end_credit", {31'd0, credit_release}, 32'd0);
`else
        chk("wrap_end_credit", {31'd0, credit_release}, 32'd1);
`endif
        tick();
        chk("wrap_idle_credit", {31'd0, credit_release}, 32'd0);

`ifdef PRED_PIPE_RX_BYPASS_EN
        // Same-cycle bypass when empty
        in_pred   = 1'b1;
        in_data   = 8'h9A;
        out_ready = 1'b1;
        #1;
        chk("byp_valid", {31'd0, out_valid}, 32'd1);
        chk("byp_data",  {24'd0, out_data},  32'h9A);
        tick();
        in_pred = 1'b0;
        #1;
        chk("byp_occ",    {29'd0, occupancy},      32'd0);
        chk("byp_credit", {31'd0, credit_release}, 32'd1);
        chk("byp_after",  {31'd0, out_valid},      32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
